// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared op codes, FSM states and operand-select bits for calc_engine
//
// Contents:
//   op_t / OP_*     3-bit operation codes
//   state_t / S_*   sequencing FSM state encodings
//   SRC_A_BIT/B_BIT bit positions within src_sel
package calc_pkg;

  typedef logic [2:0] op_t;
  typedef logic [2:0] state_t;

  localparam op_t OP_ADD  = 3'b000;
  localparam op_t OP_SUB  = 3'b001;
  localparam op_t OP_AND  = 3'b010;
  localparam op_t OP_OR   = 3'b011;
  localparam op_t OP_XOR  = 3'b100;
  localparam op_t OP_MUL  = 3'b101;
  localparam op_t OP_PASS = 3'b110;
  localparam op_t OP_CLR  = 3'b111;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_EXEC  = 3'd2;
  localparam state_t S_MUL   = 3'd3;
  localparam state_t S_WB    = 3'd4;

  localparam int SRC_A_BIT = 0;
  localparam int SRC_B_BIT = 1;

endpackage

// File: rtl/calc_regfile.sv
// rtl/calc_regfile.sv - register file with two combinational reads and one synchronous write
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears every entry)
//   raddr_a/rdata_a   read port A (combinational)
//   raddr_b/rdata_b   read port B (combinational)
//   we, waddr, wdata  write port, captured on the rising edge when we=1
module calc_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/calc_engine.sv
// rtl/calc_engine.sv - sequenced calculator: operand fetch, ALU/iterative multiply, register write-back
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                command request, only honoured while busy=0
//   op, src_sel          operation and operand source selection
//   in1, in2             external operands
//   raa, rab, wa         register read addresses (A, B) and write-back address
//   busy                 high whenever a command is in flight
//   done                 one-cycle pulse when out/zero/carry are updated
//   out, zero, carry     registered result and flags of the last completed command
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [1:0]       src_sel,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [AW-1:0]    raa,
  input  logic [AW-1:0]    rab,
  input  logic [AW-1:0]    wa,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry
);

  // Counter spans 0..WIDTH: WIDTH shift-add steps plus one finalising cycle.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  state_t             state;
  op_t                op_q;
  logic [1:0]         src_q;
  logic [WIDTH-1:0]   in1_q, in2_q;
  logic [AW-1:0]      raa_q, rab_q, wa_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] mcand, acc;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   res_q;
  logic               cy_q;
  logic [WIDTH-1:0]   out_q;
  logic               zero_q, carry_q, done_q;

  logic [WIDTH-1:0]   rd_a, rd_b;
  logic [WIDTH-1:0]   opnd_a, opnd_b;
  logic [WIDTH:0]     sum, dif;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cy;
  logic [2*WIDTH-1:0] acc_next;

  calc_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr_a(raa_q),
    .rdata_a(rd_a),
    .raddr_b(rab_q),
    .rdata_b(rd_b),
    .we     (state == S_WB),
    .waddr  (wa_q),
    .wdata  (res_q)
  );

  assign opnd_a = src_q[SRC_A_BIT] ? rd_a : in1_q;
  assign opnd_b = src_q[SRC_B_BIT] ? rd_b : in2_q;

  // One extra MSB gives carry-out for ADD and borrow for SUB.
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign dif = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    case (op_q)
      OP_ADD:  begin alu_res = sum[WIDTH-1:0]; alu_cy = sum[WIDTH]; end
      OP_SUB:  begin alu_res = dif[WIDTH-1:0]; alu_cy = dif[WIDTH]; end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_PASS: alu_res = a_q;
      default: alu_res = '0;
    endcase
  end

  // b_q is consumed LSB-first while mcand shifts left, so each step adds A*2^i.
  assign acc_next = b_q[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      raa_q   <= '0;
      rab_q   <= '0;
      wa_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            src_q <= src_sel;
            in1_q <= in1;
            in2_q <= in2;
            raa_q <= raa;
            rab_q <= rab;
            wa_q  <= wa;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          a_q <= opnd_a;
          b_q <= opnd_b;
          if (op_q == OP_MUL) begin
            mcand <= {{WIDTH{1'b0}}, opnd_a};
            acc   <= '0;
            cnt   <= '0;
            state <= S_MUL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q <= alu_res;
          cy_q  <= alu_cy;
          state <= S_WB;
        end
        S_MUL: begin
          if (cnt == CNT_LAST) begin
            res_q <= acc[WIDTH-1:0];
            cy_q  <= |acc[2*WIDTH-1:WIDTH];
            state <= S_WB;
          end else begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            b_q   <= b_q >> 1;
            cnt   <= cnt + CW'(1);
          end
        end
        S_WB: begin
          out_q   <= res_q;
          zero_q  <= (res_q == '0);
          carry_q <= cy_q;
          done_q  <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign done  = done_q;
  assign out   = out_q;
  assign zero  = zero_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_calc_engine.sv
// tb/tb_calc_engine.sv - self-checking bench for calc_engine against an arithmetic reference model
module tb_calc_engine;
  import calc_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [1:0] src_sel = '0;
  logic [7:0] in1 = '0, in2 = '0;
  logic [1:0] raa = '0, rab = '0, wa = '0;
  logic       busy, done, zero, carry;
  logic [7:0] out;

  int pass_cnt = 0;
  int total_cnt = 0;
  int mreg [D];

  calc_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_sel(src_sel),
    .in1(in1), .in2(in2), .raa(raa), .rab(rab), .wa(wa),
    .busy(busy), .done(done), .out(out), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void ref_calc(input int c_op, input int a, input int b,
                                   output int res, output int cy);
    int m;
    int r;
    m = 1 << W;
    cy = 0;
    case (c_op)
      0: begin r = a + b; cy = (r >= m) ? 1 : 0; res = r % m; end
      1: begin cy = (a < b) ? 1 : 0; res = (a - b + m) % m; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin r = a * b; cy = (r >= m) ? 1 : 0; res = r % m; end
      6: res = a;
      default: res = 0;
    endcase
  endfunction

  // Issues a command (starting right now, off the clock edge), waits for done and
  // checks latency, result and flags. inj >= 0 fires a bogus start that many cycles
  // after acceptance, while the engine is busy.
  task automatic do_cmd(input logic [2:0] c_op, input logic [1:0] c_src,
                        input logic [7:0] c_in1, input logic [7:0] c_in2,
                        input logic [1:0] c_raa, input logic [1:0] c_rab,
                        input logic [1:0] c_wa, input int inj);
    int n, ea, eb, er, ec;
    ea = c_src[0] ? mreg[c_raa] : int'(c_in1);
    eb = c_src[1] ? mreg[c_rab] : int'(c_in2);
    ref_calc(int'(c_op), ea, eb, er, ec);
    op = c_op; src_sel = c_src; in1 = c_in1; in2 = c_in2;
    raa = c_raa; rab = c_rab; wa = c_wa; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n == inj) begin
        start = 1'b1;
        op = 3'($urandom); src_sel = 2'($urandom);
        in1 = 8'($urandom); in2 = 8'($urandom);
        raa = 2'($urandom); rab = 2'($urandom); wa = 2'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk("latency", n, (c_op == OP_MUL) ? 3 + W : 3);
    chk("done", done, 1);
    chk("out", out, er);
    chk("zero", zero, (er == 0) ? 1 : 0);
    chk("carry", carry, ec);
    mreg[c_wa] = er;
  endtask

  task automatic quiet_check(input string tag, input int cycles);
    int extra;
    extra = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    chk(tag, extra, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < D; i++) mreg[i] = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_zero", zero, 1);
    chk("rst_carry", carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic cases
    do_cmd(OP_ADD, 2'b00, 8'd200, 8'd100, 2'd0, 2'd0, 2'd1, -1);
    chk("add_out", out, 44);
    chk("add_carry", carry, 1);
    do_cmd(OP_PASS, 2'b01, 8'd0, 8'd0, 2'd1, 2'd0, 2'd3, -1);
    chk("reg1_read", out, 44);
    do_cmd(OP_SUB, 2'b00, 8'd5, 8'd7, 2'd0, 2'd0, 2'd0, -1);
    chk("sub_out", out, 254);
    chk("sub_borrow", carry, 1);
    do_cmd(OP_SUB, 2'b00, 8'd7, 8'd7, 2'd0, 2'd0, 2'd0, -1);
    chk("sub_zero", zero, 1);
    do_cmd(OP_MUL, 2'b00, 8'd15, 8'd17, 2'd0, 2'd0, 2'd0, -1);
    chk("mul_out", out, 255);
    chk("mul_carry", carry, 0);
    do_cmd(OP_MUL, 2'b00, 8'd16, 8'd16, 2'd0, 2'd0, 2'd0, -1);
    chk("mul_ovf_zero", zero, 1);
    chk("mul_ovf_carry", carry, 1);

    // Back-to-back chaining, including self-referencing read/write of reg2
    do_cmd(OP_PASS, 2'b00, 8'd9, 8'd0, 2'd0, 2'd0, 2'd2, -1);
    chk("chain_pass", out, 9);
    do_cmd(OP_ADD, 2'b11, 8'd0, 8'd0, 2'd2, 2'd2, 2'd2, -1);
    chk("chain_add", out, 18);
    do_cmd(OP_PASS, 2'b01, 8'd0, 8'd0, 2'd2, 2'd0, 2'd0, -1);
    chk("reg2_read", out, 18);

    // Starts issued while busy must be ignored
    quiet_check("pre_busy_quiet", 2);
    do_cmd(OP_XOR, 2'b00, 8'hA5, 8'h0F, 2'd0, 2'd0, 2'd3, 1);
    quiet_check("exec_ignore", 15);
    do_cmd(OP_MUL, 2'b00, 8'd13, 8'd11, 2'd0, 2'd0, 2'd1, 5);
    quiet_check("mul_ignore", 15);

    // Randomised commands against the model
    for (int t = 0; t < 40; t++) begin
      do_cmd(3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
             2'($urandom), 2'($urandom), 2'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : -1);
    end

    // Reset during the MUL iterations: abort, no write-back, regfile cleared
    quiet_check("pre_reset_quiet", 1);
    op = OP_MUL; src_sel = 2'b00; in1 = 8'd200; in2 = 8'd3; wa = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out", out, 0);
    chk("abort_zero", zero, 1);
    chk("abort_carry", carry, 0);
    for (int i = 0; i < D; i++) mreg[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet_check("abort_quiet", 15);
    for (int r = 0; r < D; r++) begin
      do_cmd(OP_PASS, 2'b01, 8'hFF, 8'hFF, 2'(r), 2'd0, 2'(r), -1);
      chk("cleared_reg", out, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
